// File: rtl/b5_sequence_checker.sv
// Mod-5 count stream receiver: locks on, flags and counts sequence errors.
// Optional stall watchdog: define B5_CHECK_TIMEOUT_EN.
module b5_sequence_checker #(
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_W       = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       Q_IN,
  output logic [4:0]       ONEHOT,
  output logic             LOCKED,
  output logic             ERR,
  output logic             WRAP,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             STALL
);

  typedef enum logic [1:0] {
    S_HUNT,
    S_CHECK,
    S_LOCKED
  } state_t;

  if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_bad_lock
    $error("LOCK_CNT out of range");
  end
  if (UNLOCK_ERRS < 1 || UNLOCK_ERRS > 15) begin : g_bad_unlock
    $error("UNLOCK_ERRS out of range");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT out of range");
  end

  state_t           state, state_n;
  logic [2:0]       prev, prev_n;
  logic [3:0]       match, match_n;
  logic [3:0]       miss, miss_n;
  logic             err_n, wrap_n;
  logic [ERR_W-1:0] cnt_n;
  logic             legal;
  logic [2:0]       expected;

  assign legal    = (Q_IN <= 3'd4);
  assign expected = (prev == 3'd4) ? 3'd0 : prev + 3'd1;

`ifdef B5_CHECK_TIMEOUT_EN
  logic [7:0] idle, idle_n;
  logic       stall, stall_n;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_HUNT;
      prev    <= '0;
      match   <= '0;
      miss    <= '0;
      ERR     <= 1'b0;
      WRAP    <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      state   <= state_n;
      prev    <= prev_n;
      match   <= match_n;
      miss    <= miss_n;
      ERR     <= err_n;
      WRAP    <= wrap_n;
      ERR_CNT <= cnt_n;
    end
  end

`ifdef B5_CHECK_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      idle  <= '0;
      stall <= 1'b0;
    end else begin
      idle  <= idle_n;
      stall <= stall_n;
    end
  end

  assign STALL = stall;
`else
  assign STALL = 1'b0;
`endif

  always_comb begin
    state_n = state;
    prev_n  = prev;
    match_n = match;
    miss_n  = miss;
    err_n   = 1'b0;
    wrap_n  = 1'b0;
    cnt_n   = ERR_CNT;
`ifdef B5_CHECK_TIMEOUT_EN
    idle_n  = idle;
    stall_n = stall;
`endif
    if (EN) begin
`ifdef B5_CHECK_TIMEOUT_EN
      idle_n = '0;
`endif
      unique case (state)
        S_HUNT: begin
          if (legal) begin
            prev_n  = Q_IN;
            match_n = '0;
            state_n = S_CHECK;
          end
        end
        S_CHECK: begin
          if (!legal) begin
            state_n = S_HUNT;
          end else if (Q_IN == expected) begin
            prev_n  = Q_IN;
            match_n = match + 4'd1;
            if (match_n == 4'(LOCK_CNT)) begin
              state_n = S_LOCKED;
              miss_n  = '0;
            end
          end else begin
            prev_n  = Q_IN;
            match_n = '0;
          end
        end
        S_LOCKED: begin
          if (legal && Q_IN == expected) begin
            prev_n = Q_IN;
            miss_n = '0;
            wrap_n = (prev == 3'd4);
          end else begin
            err_n  = 1'b1;
            miss_n = miss + 4'd1;
            if (ERR_CNT != '1) cnt_n = ERR_CNT + 1'b1;
            // Illegal samples coast on the predicted value
            prev_n = legal ? Q_IN : expected;
            if (miss_n == 4'(UNLOCK_ERRS)) state_n = S_HUNT;
          end
        end
        default: state_n = S_HUNT;
      endcase
    end
`ifdef B5_CHECK_TIMEOUT_EN
    else if (state == S_LOCKED) begin
      if (idle == 8'(TIMEOUT - 1)) begin
        state_n = S_HUNT;
        stall_n = 1'b1;
        idle_n  = '0;
      end else begin
        idle_n = idle + 8'd1;
      end
    end
`endif
  end

  assign LOCKED = (state == S_LOCKED);
  assign ONEHOT = (state == S_HUNT) ? 5'b0 : (5'b00001 << prev);

endmodule

// File: tb/tb_b5_sequence_checker.sv
// Self-checking bench for b5_sequence_checker: directed plan plus random
// stream against a spec-level reference model.
module tb_b5_sequence_checker;

  localparam int LOCK_CNT    = 4;
  localparam int UNLOCK_ERRS = 2;
  localparam int ERR_W       = 3;
  localparam int TIMEOUT     = 16;
  localparam int CNT_MAX     = (1 << ERR_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             EN = 1'b0;
  logic [2:0]       Q_IN = '0;
  logic [4:0]       ONEHOT;
  logic             LOCKED;
  logic             ERR;
  logic             WRAP;
  logic [ERR_W-1:0] ERR_CNT;
  logic             STALL;

  b5_sequence_checker #(
    .LOCK_CNT(LOCK_CNT),
    .UNLOCK_ERRS(UNLOCK_ERRS),
    .ERR_W(ERR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .Q_IN(Q_IN),
    .ONEHOT(ONEHOT),
    .LOCKED(LOCKED),
    .ERR(ERR),
    .WRAP(WRAP),
    .ERR_CNT(ERR_CNT),
    .STALL(STALL)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 hunting, 1 checking, 2 locked
  int mode = 0;
  int m_prev = 0;
  int runs = 0;
  int misses = 0;
  int errs = 0;
  int idle = 0;
  bit stall = 0;
  bit m_err = 0;
  bit m_wrap = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t got %0d exp %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model(input bit rst, input bit en, input int q);
    bit legal;
    int expv;
    m_err  = 0;
    m_wrap = 0;
    if (rst) begin
      mode = 0; m_prev = 0; runs = 0; misses = 0;
      errs = 0; idle = 0; stall = 0;
      return;
    end
    if (!en) begin
`ifdef B5_CHECK_TIMEOUT_EN
      if (mode == 2) begin
        idle++;
        if (idle >= TIMEOUT) begin
          mode = 0; stall = 1; idle = 0;
        end
      end
`endif
      return;
    end
    idle  = 0;
    legal = (q < 5);
    expv  = (m_prev + 1) % 5;
    case (mode)
      0: if (legal) begin
        m_prev = q; runs = 0; mode = 1;
      end
      1: if (!legal) mode = 0;
      else if (q == expv) begin
        m_prev = q; runs++;
        if (runs == LOCK_CNT) begin
          mode = 2; misses = 0;
        end
      end else begin
        m_prev = q; runs = 0;
      end
      default: if (legal && q == expv) begin
        m_wrap = (q == 0); m_prev = q; misses = 0;
      end else begin
        m_err = 1;
        if (errs < CNT_MAX) errs++;
        misses++;
        m_prev = legal ? q : expv;
        if (misses == UNLOCK_ERRS) mode = 0;
      end
    endcase
  endtask

  task automatic step(input bit rst, input bit en, input int q,
                      input string tag);
    RST  = rst;
    EN   = en;
    Q_IN = 3'(q);
    @(posedge CLK);
    model(rst, en, q);
    #1;
    chk({tag, ".onehot"}, 32'(ONEHOT), (mode == 0) ? 0 : (1 << m_prev));
    chk({tag, ".locked"}, 32'(LOCKED), 32'(mode == 2));
    chk({tag, ".err"}, 32'(ERR), 32'(m_err));
    chk({tag, ".wrap"}, 32'(WRAP), 32'(m_wrap));
    chk({tag, ".err_cnt"}, 32'(ERR_CNT), errs);
    chk({tag, ".stall"}, 32'(STALL), 32'(stall));
  endtask

  task automatic feed(input int q, input string tag);
    step(0, 1, q, tag);
  endtask

  task automatic lock_seq(input string tag);
    for (int i = 0; i < 5; i++) feed(i, tag);
  endtask

  initial begin
    int r;
    int q;
    bit en;
    step(1, 1, 0, "reset");
    step(1, 0, 0, "reset2");

    lock_seq("lock");
    chk("lock.const_locked", 32'(LOCKED), 1);
    chk("lock.const_onehot", 32'(ONEHOT), 32'b10000);

    feed(0, "wrap");
    chk("wrap.const", 32'(WRAP), 1);
    chk("wrap.const_onehot", 32'(ONEHOT), 32'b00001);
    step(0, 0, 0, "wrap_idle");
    chk("wrap.one_cycle", 32'(WRAP), 0);

    feed(1, "fly"); feed(2, "fly"); feed(7, "fly_bad");
    chk("fly.const_err", 32'(ERR), 1);
    feed(4, "fly_ok");
    chk("fly.const_locked", 32'(LOCKED), 1);
    chk("fly.const_cnt", 32'(ERR_CNT), 1);

    feed(2, "unlock"); feed(0, "unlock_last");
    chk("unlock.const_err", 32'(ERR), 1);
    chk("unlock.const_locked", 32'(LOCKED), 0);
    feed(3, "unlock");
    lock_seq("relock");

    for (int k = 0; k < 4; k++) begin
      feed(7, "sat"); feed(7, "sat");
      lock_seq("sat_relock");
    end
    chk("sat.const_cnt", 32'(ERR_CNT), CNT_MAX);
    feed(1, "mid"); feed(2, "mid");
    step(1, 1, 3, "mid_rst");
    chk("mid_rst.const_locked", 32'(LOCKED), 0);

    lock_seq("stall_lock");
    for (int i = 0; i < TIMEOUT + 4; i++) step(0, 0, i % 8, "idle");
    step(1, 0, 0, "rst_stall");

    for (int i = 0; i < 4000; i++) begin
      r  = $urandom_range(0, 999);
      en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 99) < 75) q = (m_prev + 1) % 5;
      else q = $urandom_range(0, 7);
      if (i % 500 == 250 && mode == 2) begin
        for (int j = 0; j < TIMEOUT + 1; j++) step(0, 0, 0, "rnd_idle");
      end
      step(r < 4, en, q, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
